// File: rtl/user_uart_tx_if.sv
// ---------------------------------------------------------------------------
// user_uart_tx_if
// Byte push channel into the user-area UART transmitter.
//   tx_data  : byte to queue (producer -> transmitter)
//   tx_valid : push request (producer -> transmitter)
//   tx_ready : transmitter FIFO has room (transmitter -> producer)
// A byte is taken on the rising clock edge where tx_valid && tx_ready.
// ---------------------------------------------------------------------------
interface user_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/user_uart_tx.sv
// ---------------------------------------------------------------------------
// user_uart_tx
// 8N1 UART transmitter with a byte FIFO, driving one pad toward a UART
// receiver. Bytes are serialised LSB first; one bit lasts clk_div+1 clocks.
// Ports:
//   wb_clk_i   : system clock
//   wb_rst_i   : asynchronous reset, active high
//   clk_div    : bit period minus one (0 behaves as 1), latched per frame
//   tx_en      : 1 = start new frames, 0 = finish current frame, then idle
//   tx_if      : byte push channel (tx_data / tx_valid / tx_ready)
//   tx_o       : registered serial line, idle high
//   busy       : frame in progress (start, data or stop bit)
//   fifo_count : bytes queued, excluding the byte being shifted out
// ---------------------------------------------------------------------------
module user_uart_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [DIV_WIDTH-1:0]          clk_div,
  input  logic                          tx_en,
  user_uart_tx_if.slave                 tx_if,
  output logic                          tx_o,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               state_q,   state_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q,   shift_d;
  logic                 tx_q,      tx_d;
  logic [CW-1:0]        count_q,   count_d;
  logic [PW-1:0]        rd_ptr_q,  rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q,  wr_ptr_d;
  logic                 tx_ready_q, tx_ready_d;
  logic [7:0]           fifo_mem [FIFO_DEPTH];

  logic                 push;
  logic                 pop;
  logic                 can_pop;
  logic                 bit_end;
  logic [DIV_WIDTH-1:0] eff_div;

  // Room is judged from the registered count, so a pop in the same cycle
  // never makes space for a push while the FIFO is full.
  assign push    = tx_if.tx_valid && tx_ready_q;
  assign can_pop = tx_en && (count_q != '0);
  assign bit_end = (div_cnt_q == div_lat_q);
  assign eff_div = (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    div_lat_d = div_lat_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    // tx_d is the line level for the state being entered, so tx_o changes on
    // the same edge as the state register.
    unique case (state_q)
      S_IDLE: begin
        tx_d      = 1'b1;
        div_cnt_d = '0;
        if (can_pop) begin
          pop       = 1'b1;
          shift_d   = fifo_mem[rd_ptr_q];
          div_lat_d = eff_div;
          state_d   = S_START;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          div_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = S_DATA;
          tx_d      = shift_q[0];
        end else begin
          div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          div_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          div_cnt_d = '0;
          if (can_pop) begin
            // Chain straight into the next start bit: no idle gap.
            pop       = 1'b1;
            shift_d   = fifo_mem[rd_ptr_q];
            div_lat_d = eff_div;
            state_d   = S_START;
            tx_d      = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    tx_ready_d = (count_d < CW'(FIFO_DEPTH));
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      div_lat_q  <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_lat_q  <= div_lat_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // Datapath storage carries no reset; its contents are only observed once
  // the control state says they are valid.
  always_ff @(posedge wb_clk_i) begin
    shift_q <= shift_d;
    if (push) fifo_mem[wr_ptr_q] <= tx_if.tx_data;
  end

  assign tx_if.tx_ready = tx_ready_q;
  assign tx_o           = tx_q;
  assign busy           = (state_q != S_IDLE);
  assign fifo_count     = count_q;

endmodule

// File: tb/tb_user_uart_tx.sv
module tb_user_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] clk_div = 16'd4;
  logic        tx_en = 1'b1;
  logic        tx_o;
  logic        busy;
  logic [3:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  user_uart_tx_if u_if ();

  user_uart_tx #(.FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .clk_div    (clk_div),
    .tx_en      (tx_en),
    .tx_if      (u_if),
    .tx_o       (tx_o),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Receiver model: called on a negedge; waits (bounded) for the start bit,
  // then samples every bit half a clock after it begins.
  task automatic recv_byte(input int per, output logic [7:0] b,
                           output logic stop_bit, output logic timeout);
    int n;
    n = 0;
    b = 8'h00;
    stop_bit = 1'b0;
    while (tx_o !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    timeout = (n >= 400);
    if (!timeout) begin
      for (int i = 0; i < 8; i++) begin
        repeat (per) @(negedge clk);
        b[i] = tx_o;
      end
      repeat (per) @(negedge clk);
      stop_bit = tx_o;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx_o got %b exp 1", tx_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (u_if.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", u_if.tx_ready); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [9:0] frame;
    logic       exp_bit;
    frame = {1'b1, 8'hA5, 1'b0};
    clk_div = 16'd4;
    tx_en = 1'b1;
    u_if.tx_data = 8'hA5;
    u_if.tx_valid = 1'b1;
    @(negedge clk);
    u_if.tx_valid = 1'b0;
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count_after_push got %0d exp 1", fifo_count); end
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL single_idle_before_pop got %b exp 1", tx_o); end
    @(negedge clk);
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count_after_pop got %0d exp 0", fifo_count); end
    for (int k = 0; k < 50; k++) begin
      exp_bit = frame[k / 5];
      checks++; if (tx_o !== exp_bit) begin errors++; $display("FAIL single_line_clk%0d got %b exp %b", k, tx_o, exp_bit); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_clk%0d got %b exp 1", k, busy); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL single_idle_end got %b exp 1", tx_o); end
    repeat (5) @(negedge clk);
  endtask

  // FIFO fill with tx_en low, ninth push refused, then pop/push collision
  // and the full contiguous drain.
  task automatic test_fifo_full();
    logic [7:0] bytes [9];
    bytes = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h5A, 8'h7E, 8'h10, 8'hFE, 8'h99};
    clk_div = 16'd4;
    tx_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      u_if.tx_data = bytes[i];
      u_if.tx_valid = 1'b1;
      @(negedge clk);
    end
    u_if.tx_data = 8'hEE;
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", fifo_count); end
    checks++; if (u_if.tx_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", u_if.tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_held_busy got %b exp 0", busy); end
    @(negedge clk);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ninth_push_held got %0d exp 8", fifo_count); end
    u_if.tx_data = 8'h99;
    tx_en = 1'b1;
    fork
      begin
        @(negedge clk);
        checks++; if (fifo_count !== 4'd7) begin errors++; $display("FAIL collide_count got %0d exp 7", fifo_count); end
        checks++; if (u_if.tx_ready !== 1'b1) begin errors++; $display("FAIL collide_ready got %b exp 1", u_if.tx_ready); end
        @(negedge clk);
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL refill_count got %0d exp 8", fifo_count); end
        checks++; if (u_if.tx_ready !== 1'b0) begin errors++; $display("FAIL refill_ready got %b exp 0", u_if.tx_ready); end
        u_if.tx_valid = 1'b0;
      end
      begin
        int n;
        int run;
        n = 0;
        run = 0;
        while (busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        while (busy === 1'b1 && run < 1000) begin run++; @(negedge clk); end
        checks++; if (run != 450) begin errors++; $display("FAIL drain_busy_clks got %0d exp 450", run); end
      end
      begin
        logic [7:0] b;
        logic sb;
        logic to;
        for (int k = 0; k < 9; k++) begin
          recv_byte(5, b, sb, to);
          checks++; if (to || b !== bytes[k]) begin errors++; $display("FAIL drain_byte%0d got %h exp %h timeout %b", k, b, bytes[k], to); end
          checks++; if (sb !== 1'b1) begin errors++; $display("FAIL drain_stop%0d got %b exp 1", k, sb); end
        end
      end
    join
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_o !== 1'b1) begin errors++; $display("FAIL drain_idle got busy %b tx %b exp 0 1", busy, tx_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    bytes = '{8'h00, 8'hFF, 8'h55};
    clk_div = 16'd2;
    tx_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          u_if.tx_data = bytes[i];
          u_if.tx_valid = 1'b1;
          @(negedge clk);
        end
        u_if.tx_valid = 1'b0;
      end
      begin
        logic [7:0] b;
        logic sb;
        logic to;
        for (int k = 0; k < 3; k++) begin
          recv_byte(3, b, sb, to);
          checks++; if (to || b !== bytes[k]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h timeout %b", k, b, bytes[k], to); end
          checks++; if (sb !== 1'b1) begin errors++; $display("FAIL b2b_stop%0d got %b exp 1", k, sb); end
        end
      end
    join
    repeat (10) @(negedge clk);
  endtask

  task automatic test_div_change();
    clk_div = 16'd4;
    tx_en = 1'b1;
    fork
      begin
        u_if.tx_data = 8'h0F;
        u_if.tx_valid = 1'b1;
        @(negedge clk);
        u_if.tx_data = 8'hF0;
        @(negedge clk);
        u_if.tx_valid = 1'b0;
        repeat (12) @(negedge clk);
        clk_div = 16'd9;
      end
      begin
        logic [7:0] b;
        logic sb;
        logic to;
        recv_byte(5, b, sb, to);
        checks++; if (to || b !== 8'h0F || sb !== 1'b1) begin errors++; $display("FAIL divchg_frame1 got %h stop %b exp 0f stop 1", b, sb); end
        recv_byte(10, b, sb, to);
        checks++; if (to || b !== 8'hF0 || sb !== 1'b1) begin errors++; $display("FAIL divchg_frame2 got %h stop %b exp f0 stop 1", b, sb); end
      end
    join
    repeat (15) @(negedge clk);
    clk_div = 16'd4;
  endtask

  task automatic test_reset_midframe();
    int n;
    logic [7:0] b;
    logic sb;
    logic to;
    clk_div = 16'd4;
    tx_en = 1'b1;
    u_if.tx_data = 8'h81;
    u_if.tx_valid = 1'b1;
    @(negedge clk);
    u_if.tx_data = 8'h42;
    @(negedge clk);
    u_if.tx_valid = 1'b0;
    n = 0;
    while (tx_o !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    // Middle of data bit 3: start (5) + three data bits (15) + 2.
    repeat (22) @(negedge clk);
    checks++; if (busy !== 1'b1 || fifo_count !== 4'd1) begin errors++; $display("FAIL pre_reset got busy %b count %0d exp 1 1", busy, fifo_count); end
    rst = 1'b1;
    #1;
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL async_rst_tx got %b exp 1", tx_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b exp 0", busy); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL async_rst_count got %0d exp 0", fifo_count); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_o !== 1'b1) begin errors++; $display("FAIL post_rst_idle got busy %b tx %b exp 0 1", busy, tx_o); end
    fork
      begin
        u_if.tx_data = 8'h3C;
        u_if.tx_valid = 1'b1;
        @(negedge clk);
        u_if.tx_valid = 1'b0;
      end
      begin
        recv_byte(5, b, sb, to);
        checks++; if (to || b !== 8'h3C || sb !== 1'b1) begin errors++; $display("FAIL post_rst_byte got %h stop %b exp 3c stop 1", b, sb); end
      end
    join
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL post_rst_end got busy %b count %0d exp 0 0", busy, fifo_count); end
  endtask

  initial begin
    u_if.tx_data = 8'h00;
    u_if.tx_valid = 1'b0;
    test_reset();
    test_single_frame();
    test_fifo_full();
    test_back_to_back();
    test_div_change();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
